// File: rtl/seg7_score_decoder_if.sv
// Request/result bundle for the 7-segment score decoder.
// master: drives start and the six digit codes; slave: the decoder.
interface seg7_score_decoder_if #(
   parameter int unsigned SCORE_W = 11
);
   logic               start;
   logic [7:0]         hex0;
   logic [7:0]         hex1;
   logic [7:0]         hex2;
   logic [7:0]         hex3;
   logic [7:0]         hex4;
   logic [7:0]         hex5;
   logic               busy;
   logic               done;
   logic [SCORE_W-1:0] score;
   logic               err;
   logic               ovf;

   modport master (
      output start, hex0, hex1, hex2, hex3, hex4, hex5,
      input  busy, done, score, err, ovf
   );

   modport slave (
      input  start, hex0, hex1, hex2, hex3, hex4, hex5,
      output busy, done, score, err, ovf
   );
endinterface

// File: rtl/seg7_score_decoder.sv
// Serial decoder: six captured active-low 7-segment codes -> saturated binary score.
// Optional macro SEG7_DECODE_BLANK_EN: a blank digit (all segments off) decodes as 0 without error.
module seg7_score_decoder #(
   parameter int unsigned SCORE_W = 11
) (
   input logic                 clk,
   input logic                 reset,
   seg7_score_decoder_if.slave bus
);

   localparam int unsigned ACC_W      = 20;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned HEX_W      = 8;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned CMP_W      = 64;

   localparam logic [IDX_W-1:0] IDX_MSD   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CMP_W-1:0] SCORE_MAX = (CMP_W'(1) << SCORE_W) - CMP_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                              state_q, state_d;
   logic [NUM_DIGITS-1:0][HEX_W-1:0]    shadow_q, shadow_d;
   logic [ACC_W-1:0]                    acc_q, acc_d;
   logic [IDX_W-1:0]                    idx_q, idx_d;
   logic                                err_flag_q, err_flag_d;
   logic                                busy_q, busy_d;
   logic                                done_q, done_d;
   logic [SCORE_W-1:0]                  score_q, score_d;
   logic                                err_q, err_d;
   logic                                ovf_q, ovf_d;

   logic [HEX_W-1:0]                    cur_code_c;
   logic [DIGIT_W-1:0]                  cur_digit_c;
   logic                                cur_valid_c;
   logic [ACC_W-1:0]                    acc_mac_c;
   logic                                acc_ovf_c;

   // Segment pattern (dp stripped) -> {valid, digit}; unknown patterns give digit 0.
   function automatic logic [DIGIT_W:0] decode_seg(input logic [SEG_W-1:0] seg);
      logic [DIGIT_W:0] res;
      res = {1'b0, DIGIT_W'(0)};
      case (seg)
         7'h40:   res = {1'b1, DIGIT_W'(0)};
         7'h79:   res = {1'b1, DIGIT_W'(1)};
         7'h24:   res = {1'b1, DIGIT_W'(2)};
         7'h30:   res = {1'b1, DIGIT_W'(3)};
         7'h19:   res = {1'b1, DIGIT_W'(4)};
         7'h12:   res = {1'b1, DIGIT_W'(5)};
         7'h02:   res = {1'b1, DIGIT_W'(6)};
         7'h78:   res = {1'b1, DIGIT_W'(7)};
         7'h00:   res = {1'b1, DIGIT_W'(8)};
         7'h18:   res = {1'b1, DIGIT_W'(9)};
`ifdef SEG7_DECODE_BLANK_EN
         7'h7F:   res = {1'b1, DIGIT_W'(0)};
`endif
         default: res = {1'b0, DIGIT_W'(0)};
      endcase
      return res;
   endfunction

   // Datapath for the digit currently selected by the index.
   always_comb begin
      cur_code_c                 = shadow_q[idx_q];
      {cur_valid_c, cur_digit_c} = decode_seg(cur_code_c[SEG_W-1:0]);
      acc_mac_c                  = (acc_q * ACC_W'(10)) + ACC_W'(cur_digit_c);
      acc_ovf_c                  = CMP_W'(acc_mac_c) > SCORE_MAX;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and next values of every datapath/output register.
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      err_flag_d = err_flag_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      score_d    = score_q;
      err_d      = err_q;
      ovf_d      = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shadow_d   = {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
               acc_d      = '0;
               err_flag_d = 1'b0;
               idx_d      = IDX_MSD;
               busy_d     = 1'b1;
               state_d    = DECODE;
            end
         end

         DECODE: begin
            acc_d      = acc_mac_c;
            err_flag_d = err_flag_q | ~cur_valid_c;
            if (idx_q == '0) begin
               // Last digit: publish the result straight from the final MAC value.
               score_d = acc_ovf_c ? '1 : SCORE_W'(acc_mac_c);
               ovf_d   = acc_ovf_c;
               err_d   = err_flag_q | ~cur_valid_c;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end

         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q   <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         err_flag_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         score_q    <= '0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         err_flag_q <= err_flag_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         score_q    <= score_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.score = score_q;
   assign bus.err   = err_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seg7_score_decoder.sv
// Directed self-checking bench for seg7_score_decoder (honours SEG7_DECODE_BLANK_EN if defined).
`timescale 1ns/1ps
module tb_seg7_score_decoder;

   localparam int unsigned SCORE_W = 11;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   seg7_score_decoder_if #(.SCORE_W(SCORE_W)) bus ();

   seg7_score_decoder #(.SCORE_W(SCORE_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic set_hex(input logic [7:0] h5, input logic [7:0] h4, input logic [7:0] h3,
                          input logic [7:0] h2, input logic [7:0] h1, input logic [7:0] h0);
      bus.hex5 = h5; bus.hex4 = h4; bus.hex3 = h3;
      bus.hex2 = h2; bus.hex1 = h1; bus.hex0 = h0;
   endtask

   // Start one conversion and report latency (edges after start edge) and the result.
   task automatic convert(input logic [7:0] h5, input logic [7:0] h4, input logic [7:0] h3,
                          input logic [7:0] h2, input logic [7:0] h1, input logic [7:0] h0,
                          output int lat, output logic [31:0] score, output logic err,
                          output logic ovf);
      lat   = -1;
      score = '0;
      err   = 1'b0;
      ovf   = 1'b0;
      @(negedge clk);
      set_hex(h5, h4, h3, h2, h1, h0);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat   = k;
            score = 32'(bus.score);
            err   = bus.err;
            ovf   = bus.ovf;
            break;
         end
      end
      if (lat < 0) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk);
         #1;
         check("done_one_cycle", 32'(bus.done), 32'd0);
      end
   endtask

   int          lat;
   logic [31:0] sc;
   logic        er;
   logic        ov;
   int          dcount;
   logic [31:0] dscore;

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      set_hex(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  32'(bus.busy),  32'd0);
      check("rst_done",  32'(bus.done),  32'd0);
      check("rst_score", 32'(bus.score), 32'd0);
      check("rst_err",   32'(bus.err),   32'd0);
      check("rst_ovf",   32'(bus.ovf),   32'd0);
      @(negedge clk);
      reset = 1'b0;

      // "001234"
      convert(8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, lat, sc, er, ov);
      check("1234_latency", 32'(lat), 32'd7);
      check("1234_score", sc, 32'd1234);
      check("1234_err", 32'(er), 32'd0);
      check("1234_ovf", 32'(ov), 32'd0);

      // "999999" saturates
      convert(8'h98, 8'h98, 8'h98, 8'h98, 8'h98, 8'h98, lat, sc, er, ov);
      check("999999_score", sc, 32'd2047);
      check("999999_ovf", 32'(ov), 32'd1);
      check("999999_err", 32'(er), 32'd0);

      // "002047" exactly at the limit
      convert(8'hC0, 8'hC0, 8'hA4, 8'hC0, 8'h99, 8'hF8, lat, sc, er, ov);
      check("2047_score", sc, 32'd2047);
      check("2047_ovf", 32'(ov), 32'd0);
      check("2047_err", 32'(er), 32'd0);

      // Valid 8 in hex2, invalid code in hex1
      convert(8'hC0, 8'hC0, 8'hC0, 8'h00, 8'h55, 8'hC0, lat, sc, er, ov);
      check("invalid_score", sc, 32'd800);
      check("invalid_err", 32'(er), 32'd1);
      check("invalid_ovf", 32'(ov), 32'd0);

      // Blank leading digits
      convert(8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, lat, sc, er, ov);
      check("blank_score", sc, 32'd1234);
`ifdef SEG7_DECODE_BLANK_EN
      check("blank_err", 32'(er), 32'd0);
`else
      check("blank_err", 32'(er), 32'd1);
`endif

      // Extra starts and hex changes while busy: one done, captured result
      @(negedge clk);
      set_hex(8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      dcount = 0;
      dscore = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i < 5) begin
            bus.start = ~bus.start;
            set_hex(8'h98, 8'h98, 8'(8'h90 + i), 8'h98, 8'h55, 8'h98);
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.done) begin
            dcount++;
            dscore = 32'(bus.score);
         end
      end
      check("busy_ignore_done_count", 32'(dcount), 32'd1);
      check("busy_ignore_score", dscore, 32'd1234);
      check("busy_ignore_err", 32'(bus.err), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("score_hold", 32'(bus.score), 32'd1234);

      // Reset three cycles after start aborts the conversion
      @(negedge clk);
      set_hex(8'h98, 8'h98, 8'h98, 8'h98, 8'h98, 8'h98);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_score", 32'(bus.score), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) dcount++;
      end
      check("abort_no_done", 32'(dcount), 32'd0);

      convert(8'hC0, 8'hC0, 8'hA4, 8'hC0, 8'h99, 8'hF8, lat, sc, er, ov);
      check("post_abort_latency", 32'(lat), 32'd7);
      check("post_abort_score", sc, 32'd2047);
      check("post_abort_ovf", 32'(ov), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
